// File: rtl/pack_sync_pkg.sv
// Shared types and constants for the frame-sync controller that sits between
// pack_finder and the DeFEC input.
package pack_sync_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    PAY   = 2'd1,
    TRACK = 2'd2
  } sync_state_t;

  localparam int cPREA_LEN = 128;

endpackage

// File: rtl/pack_sync_ctrl.sv
// Frame-sync controller: qualifies preamble hits into lock, marks payload with
// sop/eop, flywheels through missed preambles and drops lock after repeated misses.
module pack_sync_ctrl
  import pack_sync_pkg::*;
#(
  parameter int cPREA_LEN = pack_sync_pkg::cPREA_LEN,
  parameter int cPAY_LEN  = 1024,
  parameter int cWIN      = 4,
  parameter int cMISS_MAX = 3
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic [4:0]  idat,
  input  logic        ival,
  input  logic        isop,
  output logic [4:0]  odat,
  output logic        oval,
  output logic        osop,
  output logic        oeop,
  output logic        olock,
  output logic        oflywheel,
  output logic        olost,
  output logic [15:0] ofrm_cnt
);

  localparam int PW = $clog2(cPAY_LEN + 1);
  localparam int GW = $clog2(cPREA_LEN + 1);
  localparam int MW = $clog2(cMISS_MAX + 1);

  // gap_cnt value on which the last preamble symbol is predicted, and the start of the early window
  localparam logic [GW-1:0] P_C    = GW'(cPREA_LEN - 1);
  localparam logic [GW-1:0] WLO_C  = GW'(cPREA_LEN - 1 - cWIN);
  localparam logic [PW-1:0] LAST_C = PW'(cPAY_LEN - 1);
  localparam logic [MW-1:0] MMAX_C = MW'(cMISS_MAX);

  sync_state_t   state_q, state_d;
  logic [PW-1:0] pay_q, pay_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          fly_q, fly_d;
  logic          lock_q, lock_d;
  logic [15:0]   frm_q, frm_d;

  logic [4:0]    odat_q, odat_d;
  logic          oval_q, oval_d;
  logic          osop_q, osop_d;
  logic          oeop_q, oeop_d;
  logic          ofly_q, ofly_d;
  logic          olost_q, olost_d;

  // Next-state and next-output logic; nothing moves on a beat without ival.
  always_comb begin
    state_d = state_q;
    pay_d   = pay_q;
    gap_d   = gap_q;
    miss_d  = miss_q;
    fly_d   = fly_q;
    lock_d  = lock_q;
    frm_d   = frm_q;
    odat_d  = 5'd0;
    oval_d  = 1'b0;
    osop_d  = 1'b0;
    oeop_d  = 1'b0;
    ofly_d  = 1'b0;
    olost_d = 1'b0;
    if (ival) begin
      case (state_q)
        HUNT: begin
          if (isop) begin
            state_d = PAY;
            pay_d   = {PW{1'b0}};
            miss_d  = {MW{1'b0}};
            fly_d   = 1'b0;
            lock_d  = 1'b1;
          end else begin
            state_d = HUNT;
          end
        end
        PAY: begin
          oval_d = 1'b1;
          odat_d = idat;
          osop_d = (pay_q == {PW{1'b0}});
          oeop_d = (pay_q == LAST_C);
          ofly_d = fly_q;
          if (pay_q == LAST_C) begin
            state_d = TRACK;
            gap_d   = {GW{1'b0}};
            frm_d   = frm_q + 16'd1;
          end else begin
            pay_d = pay_q + PW'(1);
          end
        end
        TRACK: begin
          // A hit inside the window beats a miss on the predicted beat itself.
          if (isop && (gap_q >= WLO_C) && (gap_q <= P_C)) begin
            state_d = PAY;
            pay_d   = {PW{1'b0}};
            miss_d  = {MW{1'b0}};
            fly_d   = 1'b0;
          end else if (gap_q == P_C) begin
            if ((miss_q + MW'(1)) == MMAX_C) begin
              state_d = HUNT;
              miss_d  = {MW{1'b0}};
              lock_d  = 1'b0;
              olost_d = 1'b1;
            end else begin
              state_d = PAY;
              pay_d   = {PW{1'b0}};
              miss_d  = miss_q + MW'(1);
              fly_d   = 1'b1;
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: begin
          state_d = HUNT;
          lock_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM and counter state registers.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= HUNT;
      pay_q   <= {PW{1'b0}};
      gap_q   <= {GW{1'b0}};
      miss_q  <= {MW{1'b0}};
      fly_q   <= 1'b0;
      lock_q  <= 1'b0;
      frm_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pay_q   <= pay_d;
      gap_q   <= gap_d;
      miss_q  <= miss_d;
      fly_q   <= fly_d;
      lock_q  <= lock_d;
      frm_q   <= frm_d;
    end
  end

  // Output register stage, one cycle behind the input beat.
  always_ff @(posedge iclk) begin
    if (irst) begin
      odat_q  <= 5'd0;
      oval_q  <= 1'b0;
      osop_q  <= 1'b0;
      oeop_q  <= 1'b0;
      ofly_q  <= 1'b0;
      olost_q <= 1'b0;
    end else begin
      odat_q  <= odat_d;
      oval_q  <= oval_d;
      osop_q  <= osop_d;
      oeop_q  <= oeop_d;
      ofly_q  <= ofly_d;
      olost_q <= olost_d;
    end
  end

  assign odat      = odat_q;
  assign oval      = oval_q;
  assign osop      = osop_q;
  assign oeop      = oeop_q;
  assign olock     = lock_q;
  assign oflywheel = ofly_q;
  assign olost     = olost_q;
  assign ofrm_cnt  = frm_q;

endmodule

// File: tb/tb_pack_sync_ctrl.sv
// Self-checking bench for pack_sync_ctrl: a hand-filled vector table, a
// beat-index reference model under random stimulus, and a mid-frame reset sequence.
module tb_pack_sync_ctrl;

  localparam int PREA = 128;
  localparam int PAY  = 16;
  localparam int WIN  = 2;
  localparam int MMAX = 3;

  logic        iclk;
  logic        irst;
  logic [4:0]  idat;
  logic        ival;
  logic        isop;
  logic [4:0]  odat;
  logic        oval;
  logic        osop;
  logic        oeop;
  logic        olock;
  logic        oflywheel;
  logic        olost;
  logic [15:0] ofrm_cnt;

  int n_chk;
  int n_fail;

  pack_sync_ctrl #(
    .cPAY_LEN (PAY),
    .cWIN     (WIN),
    .cMISS_MAX(MMAX)
  ) dut (
    .iclk     (iclk),
    .irst     (irst),
    .idat     (idat),
    .ival     (ival),
    .isop     (isop),
    .odat     (odat),
    .oval     (oval),
    .osop     (osop),
    .oeop     (oeop),
    .olock    (olock),
    .oflywheel(oflywheel),
    .olost    (olost),
    .ofrm_cnt (ofrm_cnt)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  typedef struct {
    logic        rst;
    logic        v;
    logic        s;
    logic [4:0]  d;
    logic [26:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [26:0] pk(input logic va, input logic so, input logic eo,
                                     input logic lo, input logic fl, input logic ls,
                                     input logic [4:0] d, input logic [15:0] f);
    return {va, so, eo, lo, fl, ls, d, f};
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic s,
                              input logic [4:0] d, input logic [26:0] e);
    vec_t t;
    t.rst = r; t.v = v; t.s = s; t.d = d; t.exp = e;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [26:0] exp);
    logic [26:0] act;
    act = {oval, osop, oeop, olock, oflywheel, olost, odat, ofrm_cnt};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual{val,sop,eop,lock,fly,lost,dat,frm}=%h required=%h",
               nm, $time, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic v, input logic s, input logic [4:0] d);
    irst = r; ival = v; isop = s; idat = d;
    @(posedge iclk);
    #1;
  endtask

  // Reference model in absolute valid-beat indices: a frame is a window of PAY
  // beats starting at m_start; the next preamble end is predicted PREA beats after it.
  int          m_beat;
  bit          m_lock;
  int          m_start;
  bit          m_fly;
  int          m_miss;
  logic [15:0] e_frm;

  function automatic int pred_beat();
    return m_start + PAY + PREA - 1;
  endfunction

  function automatic logic [26:0] model(input bit v, input bit s, input logic [4:0] d);
    bit va, so, eo, fl, ls;
    logic [4:0] dd;
    va = 0; so = 0; eo = 0; fl = 0; ls = 0; dd = 5'd0;
    if (v) begin
      if (!m_lock) begin
        if (s) begin
          m_lock = 1; m_start = m_beat + 1; m_fly = 0; m_miss = 0;
        end
      end else if (m_beat < m_start + PAY) begin
        va = 1; dd = d; fl = m_fly;
        so = (m_beat == m_start);
        eo = (m_beat == m_start + PAY - 1);
        if (eo) e_frm = e_frm + 16'd1;
      end else if (s && m_beat >= pred_beat() - WIN) begin
        m_start = m_beat + 1; m_miss = 0; m_fly = 0;
      end else if (m_beat == pred_beat()) begin
        if (m_miss + 1 == MMAX) begin
          m_lock = 0; m_miss = 0; ls = 1;
        end else begin
          m_miss++; m_start = m_beat + 1; m_fly = 1;
        end
      end
      m_beat++;
    end
    return pk(va, so, eo, m_lock, fl, ls, dd, e_frm);
  endfunction

  // off >= 0: hit off beats before prediction while tracking; off < 0: never hit.
  task automatic run(input int n, input int off, input bit hunt_hit, input bit noise, input int pct);
    bit v, s;
    logic [4:0] d;
    logic [26:0] e;
    for (int i = 0; i < n; i++) begin
      v = ($urandom_range(99) < pct);
      d = 5'($urandom);
      s = 0;
      if (!v) s = 1'($urandom);
      else if (!m_lock) s = hunt_hit;
      else if (m_beat < m_start + PAY) s = noise && ($urandom_range(5) == 0);
      else if (off >= 0 && m_beat == pred_beat() - off) s = 1;
      else if (noise && m_beat < pred_beat() - WIN - 1) s = ($urandom_range(15) == 0);
      e = model(v, s, d);
      apply(1'b0, v, s, d);
      chk("model_beat", e);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    irst = 1'b1; ival = 1'b0; isop = 1'b0; idat = 5'd0;

    tbl.push_back(mk(1, 0, 0, 5'd0,  pk(0, 0, 0, 0, 0, 0, 5'd0, 16'd0)));
    tbl.push_back(mk(0, 1, 0, 5'd3,  pk(0, 0, 0, 0, 0, 0, 5'd0, 16'd0)));
    tbl.push_back(mk(0, 1, 1, 5'd5,  pk(0, 0, 0, 1, 0, 0, 5'd0, 16'd0)));
    tbl.push_back(mk(0, 1, 0, 5'd7,  pk(1, 1, 0, 1, 0, 0, 5'd7, 16'd0)));
    tbl.push_back(mk(0, 0, 1, 5'd9,  pk(0, 0, 0, 1, 0, 0, 5'd0, 16'd0)));
    tbl.push_back(mk(0, 1, 1, 5'd11, pk(1, 0, 0, 1, 0, 0, 5'd11, 16'd0)));
    for (int k = 2; k < PAY; k++)
      tbl.push_back(mk(0, 1, 0, 5'(k + 16),
                       pk(1, 0, (k == PAY - 1), 1, 0, 0, 5'(k + 16), (k == PAY - 1) ? 16'd1 : 16'd0)));
    tbl.push_back(mk(0, 1, 0, 5'd4,  pk(0, 0, 0, 1, 0, 0, 5'd0, 16'd1)));
    tbl.push_back(mk(1, 1, 0, 5'd4,  pk(0, 0, 0, 0, 0, 0, 5'd0, 16'd0)));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].v, tbl[i].s, tbl[i].d);
      chk($sformatf("table_%0d", i), tbl[i].exp);
    end

    m_beat = 0; m_lock = 0; m_start = 0; m_fly = 0; m_miss = 0; e_frm = 16'd0;

    // Acquire at beat 200, then steady tracking
    run(200, -1, 0, 0, 100);
    run(1, 0, 1, 0, 100);
    run(144 * 5, 0, 0, 0, 100);
    // Early by the window edge (accepted), then one beat too early (missed)
    run(144 * 2, WIN, 0, 0, 100);
    run(144 * 2, WIN + 1, 0, 0, 100);
    run(144 * 2, 0, 0, 0, 100);
    // Preambles vanish: flywheel frames, then lock drop, then reacquire
    run(144 * 4, -1, 0, 0, 100);
    run(30, -1, 0, 0, 100);
    run(1, 0, 1, 0, 100);
    run(144 * 3, 0, 0, 0, 100);
    // Stalls and false hits
    run(3000, 0, 0, 0, 50);
    run(144 * 4, 0, 0, 1, 100);
    run(2000, 0, 1, 1, 70);
    for (int r = 0; r < 6; r++) run(600, int'($urandom_range(4)) - 1, 1, 1, 80);

    // Reset in the middle of payload
    apply(1'b1, 1'b0, 1'b0, 5'd0);
    chk("rst_pre", pk(0, 0, 0, 0, 0, 0, 5'd0, 16'd0));
    apply(1'b0, 1'b1, 1'b1, 5'd0);
    chk("rst_acq", pk(0, 0, 0, 1, 0, 0, 5'd0, 16'd0));
    for (int k = 0; k < 7; k++) begin
      apply(1'b0, 1'b1, 1'b0, 5'(k + 1));
      chk("rst_pay", pk(1, (k == 0), 0, 1, 0, 0, 5'(k + 1), 16'd0));
    end
    apply(1'b1, 1'b1, 1'b0, 5'd8);
    chk("rst_mid", pk(0, 0, 0, 0, 0, 0, 5'd0, 16'd0));
    for (int k = 0; k < 20; k++) begin
      apply(1'b0, 1'b1, 1'b0, 5'(k + 9));
      chk("rst_after", pk(0, 0, 0, 0, 0, 0, 5'd0, 16'd0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
